// File: rtl/dual_issue_dispatch_if.sv
// Issue-stage bundle between the fetch/dependency-check front end and the
// dual-issue dispatcher: incoming instruction pair plus the two issue registers.
interface dual_issue_dispatch_if #(
  parameter int IWIDTH    = 32,
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 di_i_valid1;
  logic                 di_i_valid2;
  logic [IWIDTH-1:0]    di_i_instr1;
  logic [IWIDTH-1:0]    di_i_instr2;
  logic [PC_WIDTH-1:0]  di_i_pc1;
  logic [PC_WIDTH-1:0]  di_i_pc2;
  logic                 di_i_force_pipe1;
  logic                 di_i_stall;
  logic                 di_i_flush;
  logic                 di_o_ready;
  logic                 di_o_valid0;
  logic [IWIDTH-1:0]    di_o_instr0;
  logic [PC_WIDTH-1:0]  di_o_pc0;
  logic                 di_o_valid1;
  logic [IWIDTH-1:0]    di_o_instr1;
  logic [PC_WIDTH-1:0]  di_o_pc1;
  logic [CNT_WIDTH-1:0] di_o_split_cnt;

  modport master (
    output di_i_valid1, di_i_valid2, di_i_instr1, di_i_instr2,
           di_i_pc1, di_i_pc2, di_i_force_pipe1, di_i_stall, di_i_flush,
    input  di_o_ready, di_o_valid0, di_o_instr0, di_o_pc0,
           di_o_valid1, di_o_instr1, di_o_pc1, di_o_split_cnt
  );

  modport slave (
    input  di_i_valid1, di_i_valid2, di_i_instr1, di_i_instr2,
           di_i_pc1, di_i_pc2, di_i_force_pipe1, di_i_stall, di_i_flush,
    output di_o_ready, di_o_valid0, di_o_instr0, di_o_pc0,
           di_o_valid1, di_o_instr1, di_o_pc1, di_o_split_cnt
  );
endinterface

// File: rtl/dual_issue_dispatch.sv
// Dual-issue dispatcher: independent pairs go out together, dependent pairs are
// split so the younger instruction re-issues alone on pipe 1 one cycle later.
module dual_issue_dispatch #(
  parameter int IWIDTH    = 32,
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 di_clk,
  input  logic                 di_rst_n,
  dual_issue_dispatch_if.slave bus
);

  typedef enum logic {PAIR = 1'b0, SPLIT = 1'b1} state_t;

  state_t               state_q, state_d;
  logic                 ready, accept, dep;

  logic                 vld0_p1, vld1_p1;
  logic [IWIDTH-1:0]    instr0_p1, instr1_p1, hold_instr;
  logic [PC_WIDTH-1:0]  pc0_p1, pc1_p1, hold_pc;
  logic [CNT_WIDTH-1:0] split_cnt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    logic [CNT_WIDTH-1:0] one;
    one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    return (&c) ? c : c + one;
  endfunction

  // Reset gates ready so nothing is accepted while the core is held in reset.
  assign ready  = di_rst_n && (state_q == PAIR) && !bus.di_i_stall && !bus.di_i_flush;
  assign accept = bus.di_i_valid1 && ready;
  assign dep    = bus.di_i_valid2 && bus.di_i_force_pipe1;

  always_comb begin
    state_d = state_q;
    if (bus.di_i_flush) begin
      state_d = PAIR;
    end else if (!bus.di_i_stall) begin
      unique case (state_q)
        PAIR:    if (accept && dep) state_d = SPLIT;
        SPLIT:   state_d = PAIR;
        default: state_d = PAIR;
      endcase
    end
  end

  always_ff @(posedge di_clk) begin
    if (!di_rst_n) state_q <= PAIR;
    else           state_q <= state_d;
  end

  // Issue-register stage: p1 outputs are one cycle after the accept edge.
  always_ff @(posedge di_clk) begin
    if (!di_rst_n) begin
      vld0_p1   <= 1'b0;
      vld1_p1   <= 1'b0;
      instr0_p1 <= '0;
      instr1_p1 <= '0;
      pc0_p1    <= '0;
      pc1_p1    <= '0;
      split_cnt <= '0;
    end else if (bus.di_i_flush) begin
      vld0_p1 <= 1'b0;
      vld1_p1 <= 1'b0;
    end else if (!bus.di_i_stall) begin
      if (state_q == SPLIT) begin
        vld0_p1   <= 1'b0;
        vld1_p1   <= 1'b1;
        instr1_p1 <= hold_instr;
        pc1_p1    <= hold_pc;
      end else if (accept) begin
        vld0_p1   <= 1'b1;
        instr0_p1 <= bus.di_i_instr1;
        pc0_p1    <= bus.di_i_pc1;
        if (dep) begin
          vld1_p1   <= 1'b0;
          split_cnt <= sat_inc(split_cnt);
        end else begin
          vld1_p1   <= bus.di_i_valid2;
          instr1_p1 <= bus.di_i_instr2;
          pc1_p1    <= bus.di_i_pc2;
        end
      end else begin
        vld0_p1 <= 1'b0;
        vld1_p1 <= 1'b0;
      end
    end
  end

  // Hold contents only matter in SPLIT; leaving SPLIT via flush/reset drops them.
  always_ff @(posedge di_clk) begin
    if (accept && dep) begin
      hold_instr <= bus.di_i_instr2;
      hold_pc    <= bus.di_i_pc2;
    end
  end

  assign bus.di_o_ready     = ready;
  assign bus.di_o_valid0    = vld0_p1;
  assign bus.di_o_instr0    = instr0_p1;
  assign bus.di_o_pc0       = pc0_p1;
  assign bus.di_o_valid1    = vld1_p1;
  assign bus.di_o_instr1    = instr1_p1;
  assign bus.di_o_pc1       = pc1_p1;
  assign bus.di_o_split_cnt = split_cnt;

endmodule

// File: tb/tb_dual_issue_dispatch.sv
// Bench for dual_issue_dispatch: a behavioural reference pushes the expected
// issue registers each cycle and the outputs are popped and compared a cycle later.
module tb_dual_issue_dispatch;
  localparam int IW = 32;
  localparam int PW = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dual_issue_dispatch_if #(.IWIDTH(IW), .PC_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

  dual_issue_dispatch #(.IWIDTH(IW), .PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .di_clk   (clk),
    .di_rst_n (rst_n),
    .bus      (bus.slave)
  );

  typedef struct {
    logic          rst;
    logic          v0;
    logic [IW-1:0] i0;
    logic [PW-1:0] p0;
    logic          v1;
    logic [IW-1:0] i1;
    logic [PW-1:0] p1;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  logic          m_split;
  logic [IW-1:0] m_hi;
  logic [PW-1:0] m_hp;
  exp_t          m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic rs, input logic v1, input logic [IW-1:0] i1,
                      input logic [PW-1:0] p1, input logic v2, input logic [IW-1:0] i2,
                      input logic [PW-1:0] p2, input logic f, input logic st, input logic fl);
    logic exp_ready;
    exp_t e;
    @(negedge clk);
    rst_n = rs;
    bus.di_i_valid1 = v1; bus.di_i_instr1 = i1; bus.di_i_pc1 = p1;
    bus.di_i_valid2 = v2; bus.di_i_instr2 = i2; bus.di_i_pc2 = p2;
    bus.di_i_force_pipe1 = f; bus.di_i_stall = st; bus.di_i_flush = fl;
    #1;
    exp_ready = rs && !m_split && !st && !fl;
    chk("ready", {63'd0, bus.di_o_ready}, {63'd0, exp_ready});
    m.rst = !rs;
    if (!rs) begin
      m.v0 = 0; m.v1 = 0; m.i0 = '0; m.p0 = '0; m.i1 = '0; m.p1 = '0; m.cnt = '0;
      m_split = 0;
    end else if (fl) begin
      m.v0 = 0; m.v1 = 0; m_split = 0;
    end else if (!st) begin
      if (m_split) begin
        m.v0 = 0; m.v1 = 1; m.i1 = m_hi; m.p1 = m_hp; m_split = 0;
      end else if (v1) begin
        m.v0 = 1; m.i0 = i1; m.p0 = p1;
        if (v2 && f) begin
          m.v1 = 0; m_hi = i2; m_hp = p2; m_split = 1;
          if (m.cnt != '1) m.cnt = m.cnt + 1'b1;
        end else begin
          m.v1 = v2; m.i1 = i2; m.p1 = p2;
        end
      end else begin
        m.v0 = 0; m.v1 = 0;
      end
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk("valid0", {63'd0, bus.di_o_valid0}, {63'd0, e.v0});
      chk("valid1", {63'd0, bus.di_o_valid1}, {63'd0, e.v1});
      if (e.v0 || e.rst) begin
        chk("instr0", {32'd0, bus.di_o_instr0}, {32'd0, e.i0});
        chk("pc0", {32'd0, bus.di_o_pc0}, {32'd0, e.p0});
      end
      if (e.v1 || e.rst) begin
        chk("instr1", {32'd0, bus.di_o_instr1}, {32'd0, e.i1});
        chk("pc1", {32'd0, bus.di_o_pc1}, {32'd0, e.p1});
      end
      chk("split_cnt", {60'd0, bus.di_o_split_cnt}, {60'd0, e.cnt});
    end
  endtask

  task automatic idle(input logic st, input logic fl);
    step(1, 0, '0, '0, 0, '0, '0, 0, st, fl);
  endtask

  task automatic pair(input logic f, input logic v2);
    step(1, 1, 32'hAAAA0001, 32'h100, v2, 32'hBBBB0002, 32'h104, f, 0, 0);
  endtask

  initial begin
    m = '{rst: 1'b1, v0: 1'b0, i0: '0, p0: '0, v1: 1'b0, i1: '0, p1: '0, cnt: '0};
    m_split = 0; m_hi = '0; m_hp = '0;
    bus.di_i_valid1 = 0; bus.di_i_valid2 = 0; bus.di_i_instr1 = '0; bus.di_i_instr2 = '0;
    bus.di_i_pc1 = '0; bus.di_i_pc2 = '0; bus.di_i_force_pipe1 = 0;
    bus.di_i_stall = 0; bus.di_i_flush = 0;

    // Reset with a pair presented: nothing accepted, everything cleared.
    step(0, 1, 32'h1234, 32'h40, 1, 32'h5678, 32'h44, 0, 0, 0);
    step(0, 1, 32'h1234, 32'h40, 1, 32'h5678, 32'h44, 0, 0, 0);
    chk("rst_cnt", {60'd0, bus.di_o_split_cnt}, 64'd0);

    // Independent pair.
    pair(0, 1);
    chk("ind_i0", {32'd0, bus.di_o_instr0}, 64'hAAAA0001);
    chk("ind_p1", {32'd0, bus.di_o_pc1}, 64'h104);
    chk("ind_ready", {63'd0, bus.di_o_ready}, 64'd1);

    // Dependent pair split over two cycles.
    pair(1, 1);
    chk("dep_pc0", {32'd0, bus.di_o_pc0}, 64'h100);
    idle(0, 0);
    chk("dep_pc1", {32'd0, bus.di_o_pc1}, 64'h104);
    chk("dep_cnt", {60'd0, bus.di_o_split_cnt}, 64'd1);
    idle(0, 0);

    // Stall for three cycles while holding the split instruction.
    pair(1, 1);
    idle(1, 0); idle(1, 0); idle(1, 0);
    chk("stall_v0", {63'd0, bus.di_o_valid0}, 64'd1);
    idle(0, 0);
    chk("stall_pc1", {32'd0, bus.di_o_pc1}, 64'h104);
    chk("stall_cnt", {60'd0, bus.di_o_split_cnt}, 64'd2);

    // Flush while split: held instruction is never issued.
    pair(1, 1);
    idle(0, 1);
    idle(0, 0);
    chk("flush_v1", {63'd0, bus.di_o_valid1}, 64'd0);

    // Stale verdict with slot 2 empty; stall and flush together.
    pair(1, 0);
    chk("stale_cnt", {60'd0, bus.di_o_split_cnt}, 64'd3);
    pair(1, 1);
    idle(1, 1);
    idle(0, 0);
    chk("sf_v1", {63'd0, bus.di_o_valid1}, 64'd0);

    // Reset in the middle of a split drops the held instruction.
    pair(1, 1);
    step(0, 0, '0, '0, 0, '0, '0, 0, 0, 0);
    idle(0, 0);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      step(1, ($urandom_range(0, 9) < 8), $urandom, $urandom,
           $urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 1),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
    end

    // Counter saturation.
    step(0, 0, '0, '0, 0, '0, '0, 0, 0, 0);
    for (int k = 0; k < 18; k++) begin
      step(1, 1, 32'h10 + k, 32'h200 + 8 * k, 1, 32'h20 + k, 32'h204 + 8 * k, 1, 0, 0);
      idle(0, 0);
    end
    chk("cnt_sat", {60'd0, bus.di_o_split_cnt}, 64'd15);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
